fifo_sync: RTL and testbench

Parametrised single-clock FIFO with first-word-fall-through read, occupancy count, programmable almost-full/almost-empty flags, synchronous flush and sticky error flags. It is the same-domain counterpart to the 1-deep async FIFO, for buffering bursts between producers and consumers clocked by one `clk`. Push and pop use the same ready/enable handshake as the rest of the memory cores.

---
 rtl/ram_dp_ar.sv | 29 ++
 rtl/fifo_sync.sv | 90 +++++++++
 tb/tb_fifo_sync.sv | 220 ++++++++++++++++++++++
 3 files changed

// File: rtl/ram_dp_ar.sv
// Dual-port RAM: synchronous write, asynchronous read.
// Intended for reuse by FIFO variants that need a fall-through read port.
`ifndef RAM_DP_AR_SV
`define RAM_DP_AR_SV
module ram_dp_ar #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 2**ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // NOTE: storage is deliberately not reset; validity is tracked by the pointers,
  // and a reset port on every word would prevent mapping onto RAM primitives.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule
`endif

// File: rtl/fifo_sync.sv
// Single-clock FWFT FIFO with occupancy count, threshold flags, flush and
// sticky overflow/underflow flags. Storage lives in ram_dp_ar.
`ifndef FIFO_SYNC_SV
`define FIFO_SYNC_SV
module fifo_sync #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 4,
  parameter int AFULL_THRESH  = (2**ADDR_WIDTH) - 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_ready,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic                  pop_ready,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2**ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF_LEVEL = AFULL_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0] AE_LEVEL = AEMPTY_THRESH[ADDR_WIDTH:0];

  logic [ADDR_WIDTH:0] wr_ptr;
  logic [ADDR_WIDTH:0] rd_ptr;
  logic                full;
  logic                empty;
  logic                push_we;
  logic                pop_rd;
  logic                clear;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                 (wr_ptr[ADDR_WIDTH-1:0] == rd_ptr[ADDR_WIDTH-1:0]);

  assign push_ready = !full;
  assign pop_ready  = !empty;
  assign push_we    = push && push_ready;
  assign pop_rd     = pop && pop_ready;
  assign clear      = rst || flush;

  assign almost_full  = (count >= AF_LEVEL);
  assign almost_empty = (count <= AE_LEVEL);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (clear) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_we) wr_ptr <= wr_ptr + 1'b1;
      if (pop_rd)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_we, pop_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && !push_ready) overflow <= 1'b1;
      // A pop on an empty FIFO that coincides with an accepted push is not an error.
      if (pop && !pop_ready && !push_we) underflow <= 1'b1;
    end
  end

  // Writes are suppressed during flush/reset so a discarded word never lands.
  ram_dp_ar #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push_we && !clear),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (push_data),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (pop_data)
  );

endmodule
`endif

// File: tb/tb_fifo_sync.sv
// Self-checking bench for fifo_sync: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, then random traffic.
module tb_fifo_sync;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int DEPTH = 16;
  localparam int AF = 12;
  localparam int AE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush = 1'b0;
  logic          push = 1'b0;
  logic [DW-1:0] push_data = '0;
  logic          push_ready;
  logic          pop = 1'b0;
  logic [DW-1:0] pop_data;
  logic          pop_ready;
  logic [AW:0]   count;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  int total = 0;
  int bad = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [DW-1:0] q[$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;
  bit can_push, can_pop, acc_push, acc_pop;

  fifo_sync #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .AFULL_THRESH  (AF),
    .AEMPTY_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .push         (push),
    .push_data    (push_data),
    .push_ready   (push_ready),
    .pop          (pop),
    .pop_data     (pop_data),
    .pop_ready    (pop_ready),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: decide acceptance from the occupancy before the edge.
  always @(posedge clk) begin
    if (rst || flush) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      can_push = (q.size() < DEPTH);
      can_pop  = (q.size() > 0);
      acc_push = push && can_push;
      acc_pop  = pop && can_pop;
      if (push && !can_push) m_ovf = 1'b1;
      if (pop && !can_pop && !acc_push) m_unf = 1'b1;
      if (acc_pop) void'(q.pop_front());
      if (acc_push) q.push_back(push_data);
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("push_ready", {31'b0, push_ready}, {31'b0, q.size() != DEPTH});
      check("pop_ready", {31'b0, pop_ready}, {31'b0, q.size() != 0});
      check("count", {27'b0, count}, q.size());
      check("almost_full", {31'b0, almost_full}, {31'b0, q.size() >= AF});
      check("almost_empty", {31'b0, almost_empty}, {31'b0, q.size() <= AE});
      check("overflow", {31'b0, overflow}, {31'b0, m_ovf});
      check("underflow", {31'b0, underflow}, {31'b0, m_unf});
      if (q.size() != 0) check("pop_data", {24'b0, pop_data}, {24'b0, q[0]});
    end
  end

  // Apply one cycle of inputs; returns #1 after the edge.
  task automatic cyc(input logic p, input logic [DW-1:0] d, input logic r, input logic f);
    push = p;
    push_data = d;
    pop = r;
    flush = f;
    @(posedge clk);
    #1;
    push = 1'b0;
    pop = 1'b0;
    flush = 1'b0;
  endtask

  int exp_v;

  initial begin
    // Reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk_en = 1'b1;
    check("rst_push_ready", {31'b0, push_ready}, 1);
    check("rst_pop_ready", {31'b0, pop_ready}, 0);
    check("rst_count", {27'b0, count}, 0);
    check("rst_aempty", {31'b0, almost_empty}, 1);
    check("rst_flags", {30'b0, overflow, underflow}, 0);

    // Fill and drain
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 10) check("afull_at_11", {31'b0, almost_full}, 0);
      if (i == 11) check("afull_at_12", {31'b0, almost_full}, 1);
    end
    check("fill_count", {27'b0, count}, 16);
    check("fill_push_ready", {31'b0, push_ready}, 0);
    for (int i = 0; i < 16; i++) begin
      check("drain_data", {24'b0, pop_data}, i);
      cyc(1'b0, 8'h00, 1'b1, 1'b0);
    end
    check("drain_pop_ready", {31'b0, pop_ready}, 0);

    // Simultaneous push/pop at mid level, across pointer wrap
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) begin
      exp_v = (i < 5) ? (8'h10 + i) : (8'h20 + i - 5);
      check("mid_data", {24'b0, pop_data}, exp_v);
      cyc(1'b1, 8'(8'h20 + i), 1'b1, 1'b0);
    end
    check("mid_count", {27'b0, count}, 5);
    for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Simultaneous push/pop when full: pushed word dropped
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hEE, 1'b1, 1'b0);
    check("full_pp_count", {27'b0, count}, 15);
    for (int i = 0; i < 14; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("full_pp_last", {24'b0, pop_data}, 8'h4F);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);

    // Simultaneous push/pop when empty
    cyc(1'b1, 8'h77, 1'b1, 1'b0);
    check("empty_pp_count", {27'b0, count}, 1);
    check("empty_pp_unf", {31'b0, underflow}, 0);
    check("empty_pp_data", {24'b0, pop_data}, 8'h77);

    // Errors
    for (int i = 0; i < 15; i++) cyc(1'b1, 8'(8'h80 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'hAA, 1'b0, 1'b0);
    check("ovf_set", {31'b0, overflow}, 1);
    check("ovf_count", {27'b0, count}, 16);
    repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("ovf_sticky", {31'b0, overflow}, 1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    check("unf_set", {31'b0, underflow}, 1);
    check("ovf_still", {31'b0, overflow}, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    check("flush_clears", {30'b0, overflow, underflow}, 0);

    // Flush mid-operation
    for (int i = 0; i < 9; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b0, 1'b1);
    check("flush_count", {27'b0, count}, 0);
    check("flush_pop_ready", {31'b0, pop_ready}, 0);
    cyc(1'b1, 8'h66, 1'b0, 1'b0);
    check("after_flush_data", {24'b0, pop_data}, 8'h66);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // FWFT latency
    push = 1'b1;
    push_data = 8'h3C;
    @(negedge clk);
    check("fwft_before", {31'b0, pop_ready}, 0);
    @(posedge clk);
    #1;
    push = 1'b0;
    check("fwft_ready", {31'b0, pop_ready}, 1);
    check("fwft_data", {24'b0, pop_data}, 8'h3C);
    cyc(1'b0, 8'h00, 1'b1, 1'b0);

    // Random traffic with phases biased toward filling and draining
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = ((i / 200) % 2 == 0) ? 75 : 25;
      if ($urandom_range(999) == 0) begin
        rst = 1'b1;
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        rst = 1'b0;
      end else begin
        cyc($urandom_range(99) < bias, 8'($urandom), $urandom_range(99) >= bias - 10,
            $urandom_range(127) == 0);
      end
    end

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
